// File: rtl/mem1r1w_port_arbiter_if.sv
// rtl/mem1r1w_port_arbiter_if.sv - requester, response and memory-port bundle for the 1R1W arbiter
interface mem1r1w_port_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic [AW-1:0]      mem_raddr;
  logic               mem_ren;
  logic [DW-1:0]      mem_rdata;
  logic [AW-1:0]      mem_waddr;
  logic               mem_wen;
  logic [DW-1:0]      mem_wdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_data,
    output mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data,
    input  mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem1r1w_port_arbiter.sv
// rtl/mem1r1w_port_arbiter.sv - round-robin sharing of one 1R1W synchronous-read memory
module mem1r1w_port_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  mem1r1w_port_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 2) ? 2 : 1;
  typedef logic [PW-1:0] ptr_t;

  // Returns {found, index}; the loop runs high-to-low so the lowest offset from ptr wins.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] cand, input ptr_t ptr);
    logic [PW:0] pick;
    int          j;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (cand[j]) pick = {1'b1, PW'(j)};
    end
    return pick;
  endfunction

  function automatic ptr_t ptr_after(input ptr_t idx);
    return (int'(idx) == NREQ - 1) ? '0 : ptr_t'(int'(idx) + 1);
  endfunction

  ptr_t            rd_ptr, wr_ptr;
  ptr_t            rd_idx, wr_idx;
  logic [PW:0]     rd_pick, wr_pick;
  logic            rd_hit, wr_hit;
  logic [NREQ-1:0] rd_cand, wr_cand;
  logic [NREQ-1:0] rd_grant, wr_grant;
  logic [NREQ-1:0] resp_valid_q;
  logic            fwd;
  logic [DW-1:0]   fwd_data_q;
  logic            same_addr;

  // Candidates vanish during reset, which forces every grant and enable low.
  assign rd_cand = reset ? (bus.req_valid & ~bus.req_write) : '0;
  assign wr_cand = reset ? (bus.req_valid &  bus.req_write) : '0;

  assign rd_pick = rr_pick(rd_cand, rd_ptr);
  assign wr_pick = rr_pick(wr_cand, wr_ptr);
  assign rd_hit  = rd_pick[PW];
  assign wr_hit  = wr_pick[PW];
  assign rd_idx  = rd_pick[PW-1:0];
  assign wr_idx  = wr_pick[PW-1:0];

  assign rd_grant = rd_hit ? (NREQ'(1) << rd_idx) : '0;
  assign wr_grant = wr_hit ? (NREQ'(1) << wr_idx) : '0;
  assign bus.req_ready = rd_grant | wr_grant;

  assign bus.mem_ren   = rd_hit;
  assign bus.mem_raddr = rd_hit ? bus.req_addr[int'(rd_idx)*AW +: AW] : '0;
  assign bus.mem_wen   = wr_hit;
  assign bus.mem_waddr = wr_hit ? bus.req_addr[int'(wr_idx)*AW +: AW] : '0;
  assign bus.mem_wdata = wr_hit ? bus.req_wdata[int'(wr_idx)*DW +: DW] : '0;

  assign same_addr = rd_hit && wr_hit && (bus.mem_raddr == bus.mem_waddr);

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = fwd ? fwd_data_q : bus.mem_rdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      resp_valid_q <= '0;
      fwd          <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      if (rd_hit) rd_ptr <= ptr_after(rd_idx);
      if (wr_hit) wr_ptr <= ptr_after(wr_idx);
      resp_valid_q <= rd_grant;
      // The macro returns old data on a same-address collision; substitute the new write data.
      fwd <= same_addr;
      if (same_addr) fwd_data_q <= bus.mem_wdata;
    end
  end
endmodule
